// File: rtl/com_uart.sv
// com_uart: com-bus responder wrapping an 8N1 UART with a single-byte TX shifter,
// a mid-bit RX sampler and a small RX FIFO; pulses interrupt with INT_CODE on com_rd.
module com_uart #(
    parameter logic [7:0]  BASE         = 8'h10,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned RX_DEPTH     = 4,
    parameter logic [7:0]  INT_CODE     = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] com_addr,
    input  logic [7:0] com_wr,
    input  logic       com_we,
    input  logic       com_re,
    output logic [7:0] com_rd,
    output logic       interrupt,
    input  logic       uart_rx,
    output logic       uart_tx
);
    localparam int unsigned   AW        = $clog2(RX_DEPTH);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic sel_data, sel_stat, sel_ctrl;
    assign sel_data = (com_addr == BASE);
    assign sel_stat = (com_addr == BASE + 8'd1);
    assign sel_ctrl = (com_addr == BASE + 8'd2);

    logic tx_busy, rx_int_en, overrun, frame_err, pending;

    // ---------------- RX FIFO ----------------
    logic [7:0]  fifo_mem [RX_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop;
    logic [7:0]  rx_shift;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = com_re && sel_data && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- RX sampler ----------------
    rx_state_e     rx_state;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic          rx_stop_done, set_ovr, set_ferr;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign rx_stop_done = (rx_state == RxStop) && (rx_cnt == BIT_LAST);
    assign push         = rx_stop_done && rx_sync && (!fifo_full || pop);
    assign set_ovr      = rx_stop_done && rx_sync && fifo_full && !pop;
    assign set_ferr     = rx_stop_done && !rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RxIdle;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RxStart;
                        rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RxStop;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (rx_cnt == BIT_LAST) rx_state <= RxIdle;
                    else                    rx_cnt   <= rx_cnt + 1'b1;
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // ---------------- TX shifter ----------------
    tx_state_e     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TxIdle;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TxIdle: begin
                    if (com_we && sel_data) begin
                        tx_state <= TxStart;
                        tx_shift <= com_wr;
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b1;
                        uart_tx  <= 1'b0;
                    end
                end
                TxStart: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= TxData;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TxData: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= TxStop;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TxStop: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_busy  <= 1'b0;
                        tx_state <= TxIdle;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // ---------------- Control, sticky flags, interrupt ----------------
    logic stat_clr;
    assign stat_clr  = com_re && sel_stat;
    // The pulse waits out any read strobe so it never collides with read data on com_rd.
    assign interrupt = pending && !com_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_int_en <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (com_we && sel_ctrl) rx_int_en <= com_wr[0];
            overrun   <= set_ovr  | (overrun   & ~stat_clr);
            frame_err <= set_ferr | (frame_err & ~stat_clr);
            pending   <= (push & rx_int_en) | (pending & ~interrupt);
        end
    end

    always_comb begin
        com_rd = 8'h00;
        if (com_re) begin
            if (sel_data) begin
                com_rd = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];
            end else if (sel_stat) begin
                com_rd = {3'b000, frame_err, overrun, fifo_full, !fifo_empty, tx_busy};
            end else if (sel_ctrl) begin
                com_rd = {7'b0000000, rx_int_en};
            end
        end else if (interrupt) begin
            com_rd = INT_CODE;
        end
    end

endmodule
